// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_WORD_W   = 32;
  localparam int DMEM_CNT_W    = 4;
  localparam int DMEM_ADDR_LSB = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the EX/MEM register and the responder.
// Latency: n/a (wires only).
// Backpressure: requester holds its request while stall_o is high, until ack_o.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                   mem_read_i;
  logic                   mem_write_i;
  logic [31:0]            addr_i;
  logic [DMEM_WORD_W-1:0] wdata_i;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]             be_i;
`endif
  logic [DMEM_WORD_W-1:0] rdata_o;
  logic                   ack_o;
  logic                   err_o;
  logic                   stall_o;

  // Requester side (pipeline MEM stage).
  modport master (
    output mem_read_i, mem_write_i, addr_i, wdata_i,
`ifdef DMEM_BYTE_EN_EN
    output be_i,
`endif
    input  rdata_o, ack_o, err_o, stall_o
  );

  // Responder side.
  modport slave (
    input  mem_read_i, mem_write_i, addr_i, wdata_i,
`ifdef DMEM_BYTE_EN_EN
    input  be_i,
`endif
    output rdata_o, ack_o, err_o, stall_o
  );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word array with per-byte write enables and registered read.
// Latency: write commits and read data registers on the same edge as we/re.
// Backpressure: none; accepts one access per cycle when enabled.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic                   re,
  input  logic [AW-1:0]          idx,
  input  logic [DMEM_WORD_W-1:0] wdata,
  input  logic [3:0]             be,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH];

  // Storage has no reset: contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read data register holds the last loaded word until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage; optional byte enables under DMEM_BYTE_EN_EN.
// Latency: ack_o LATENCY cycles after acceptance; rejected requests ack after 1 cycle.
// Backpressure: combinational stall_o holds the pipeline from request until the ack cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
    (LATENCY >= 2) ? DMEM_CNT_W'(LATENCY - 2) : '0;

  dmem_state_t            state, next_state;
  logic [DMEM_CNT_W-1:0]  cnt;
  logic [AW-1:0]          idx_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic                   wr_q;
  logic                   err_q;

  logic                   req;
  logic                   bad_req;
  logic [3:0]             be_in;
  logic                   is_idle;
  logic                   enter_done;
  logic                   op_wr;
  logic                   op_err;
  logic [AW-1:0]          op_idx;
  logic [DMEM_WORD_W-1:0] op_wdata;
  logic [3:0]             op_be;
  logic                   arr_we;
  logic                   arr_re;
  logic [DMEM_WORD_W-1:0] rdata;
  logic                   unused_addr_hi;

`ifdef DMEM_BYTE_EN_EN
  logic [3:0] be_q;
  assign be_in = bus.be_i;
`else
  assign be_in = 4'hF;
`endif

  assign req = bus.mem_read_i | bus.mem_write_i;

  // Upper address bits simply wrap away.
  assign unused_addr_hi = ^bus.addr_i[31:AW+DMEM_ADDR_LSB];

  // Reject ambiguous ops, misaligned addresses and stores that enable no byte.
  assign bad_req = (bus.mem_read_i & bus.mem_write_i)
                 | (bus.addr_i[DMEM_ADDR_LSB-1:0] != '0)
                 | (bus.mem_write_i & (be_in == 4'h0));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: accept in IDLE, count down in WAIT, DONE lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (bad_req || LATENCY == 1) ? DONE : WAIT;
      WAIT: if (cnt == '0) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch and wait counter; a request dropped mid-WAIT is ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= 4'h0;
`endif
    end else if (state == IDLE) begin
      if (req) begin
        cnt     <= CNT_INIT;
        idx_q   <= bus.addr_i[DMEM_ADDR_LSB +: AW];
        wdata_q <= bus.wdata_i;
        wr_q    <= bus.mem_write_i;
        err_q   <= bad_req;
`ifdef DMEM_BYTE_EN_EN
        be_q    <= bus.be_i;
`endif
      end
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Outputs and array strobes; the access fires on the edge that enters DONE,
  // which for LATENCY=1 is the acceptance edge itself, so IDLE uses live inputs.
  always_comb begin
    is_idle    = (state == IDLE);
    enter_done = (next_state == DONE) && (state != DONE);
    op_wr      = is_idle ? bus.mem_write_i : wr_q;
    op_err     = is_idle ? bad_req : err_q;
    op_idx     = is_idle ? bus.addr_i[DMEM_ADDR_LSB +: AW] : idx_q;
    op_wdata   = is_idle ? bus.wdata_i : wdata_q;
`ifdef DMEM_BYTE_EN_EN
    op_be      = is_idle ? bus.be_i : be_q;
`else
    op_be      = 4'hF;
`endif
    arr_we      = enter_done & ~op_err & op_wr;
    arr_re      = enter_done & ~op_err & ~op_wr;
    bus.ack_o   = (state == DONE);
    bus.err_o   = (state == DONE) & err_q;
    bus.stall_o = rst_i & ((is_idle & req) | (state == WAIT));
  end

  assign bus.rdata_o = rdata;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk_i),
    .rst_n (rst_i),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (op_idx),
    .wdata (op_wdata),
    .be    (op_be),
    .rdata (rdata)
  );

endmodule
